// File: rtl/i2s_pkg.sv
// Shared I2S definitions: channel encoding and slot bit indexing.
package i2s_pkg;

    typedef logic i2s_ch_t;

    localparam i2s_ch_t CH_LEFT  = 1'b1;
    localparam i2s_ch_t CH_RIGHT = 1'b0;

    // Bit of the left-justified slot word driven while the slot counter holds cnt.
    function automatic int unsigned slot_bit_idx(input int unsigned slot_bits,
                                                 input int unsigned cnt);
        return slot_bits - 1 - cnt;
    endfunction

endpackage

// File: rtl/i2sout_piso.sv
// Parallel-load slot shifter: holds the current slot word and drives it MSB-first,
// left-justified in the slot with zero padding after the LSB.
module i2sout_piso
    import i2s_pkg::*;
#(
    parameter int unsigned BITS_PRECISION = 4,
    parameter int unsigned SLOT_BITS      = BITS_PRECISION,
    parameter int unsigned CNT_W          = 2
) (
    input  logic                      sck,
    input  logic                      rst,
    input  logic                      load,
    input  logic [BITS_PRECISION-1:0] load_word,
    input  logic [CNT_W-1:0]          bit_cnt,
    output logic                      sd
);

    localparam int unsigned PAD_BITS = SLOT_BITS - BITS_PRECISION;

    logic [BITS_PRECISION-1:0] shift;
    logic [SLOT_BITS-1:0]      slot_word;
    logic                      sd_nxt;

    // Select the slot bit for the current count; the pad region reads as zero.
    always_comb begin
        slot_word = SLOT_BITS'(shift) << PAD_BITS;
        sd_nxt    = 1'b0;
        for (int unsigned i = 0; i < SLOT_BITS; i++) begin
            if (i == slot_bit_idx(SLOT_BITS, 32'(bit_cnt))) begin
                sd_nxt = slot_word[i];
            end
        end
    end

    always_ff @(negedge sck or negedge rst) begin
        if (!rst) begin
            shift <= '0;
            sd    <= 1'b0;
        end else begin
            sd <= sd_nxt;
            if (load) begin
                shift <= load_word;
            end
        end
    end

endmodule

// File: rtl/i2sout.sv
// I2S master transmitter: per-channel hold registers behind a valid/ready handshake,
// ws generation and MSB-first serialisation. Optional macro I2SOUT_REPEAT_ON_UNDERRUN_EN.
module i2sout
    import i2s_pkg::*;
#(
    parameter int unsigned BITS_PRECISION = 4,
    parameter int unsigned SLOT_BITS      = BITS_PRECISION
) (
    input  logic                      sck,
    input  logic                      rst,
    input  logic [BITS_PRECISION-1:0] data_out,
    input  logic                      left_rightn,
    input  logic                      data_valid,
    output logic                      data_ready,
    output logic                      ws,
    output logic                      sd,
    output logic                      underrun
);

    localparam int unsigned      CNT_W    = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_BITS - 1);

    logic [CNT_W-1:0]                bit_cnt;
    logic [1:0][BITS_PRECISION-1:0]  hold;
    logic [1:0]                      full;
    logic [1:0]                      full_nxt;
    logic                            boundary;
    logic                            accept;
    i2s_ch_t                         wr_ch;
    i2s_ch_t                         load_ch;
    logic [BITS_PRECISION-1:0]       load_word;

    always_comb begin
        wr_ch      = left_rightn;
        data_ready = ~full[wr_ch];
        accept     = data_valid & ~full[wr_ch];
        boundary   = (bit_cnt == CNT_LAST);
        load_ch    = ws ? CH_RIGHT : CH_LEFT;
    end

    // An empty hold still carries the last word loaded for that channel.
    always_comb begin
`ifdef I2SOUT_REPEAT_ON_UNDERRUN_EN
        load_word = hold[load_ch];
`else
        load_word = full[load_ch] ? hold[load_ch] : '0;
`endif
    end

    // A same-edge accept into an empty hold wins over the load's clear.
    always_comb begin
        full_nxt = full;
        if (boundary) begin
            full_nxt[load_ch] = 1'b0;
        end
        if (accept) begin
            full_nxt[wr_ch] = 1'b1;
        end
    end

    always_ff @(negedge sck or negedge rst) begin
        if (!rst) begin
            ws       <= 1'b0;
            underrun <= 1'b0;
            bit_cnt  <= CNT_LAST;
            hold     <= '0;
            full     <= '0;
        end else begin
            full <= full_nxt;
            if (accept) begin
                hold[wr_ch] <= data_out;
            end
            if (boundary) begin
                ws       <= ~ws;
                underrun <= ~full[load_ch];
                bit_cnt  <= '0;
            end else begin
                underrun <= 1'b0;
                bit_cnt  <= bit_cnt + CNT_W'(1);
            end
        end
    end

    i2sout_piso #(
        .BITS_PRECISION(BITS_PRECISION),
        .SLOT_BITS     (SLOT_BITS),
        .CNT_W         (CNT_W)
    ) u_piso (
        .sck      (sck),
        .rst      (rst),
        .load     (boundary),
        .load_word(load_word),
        .bit_cnt  (bit_cnt),
        .sd       (sd)
    );

endmodule
